// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and the default bit period.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_stream_if.sv
// Valid/ready byte stream carrying received bytes from the UART receiver to its consumer.
interface uart_rx_stream_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] o_RX_Byte;
  logic                      o_RX_Byte_tvalid;
  logic                      i_RX_Byte_tready;

  modport master (output o_RX_Byte, output o_RX_Byte_tvalid, input  i_RX_Byte_tready);
  modport slave  (input  o_RX_Byte, input  o_RX_Byte_tvalid, output i_RX_Byte_tready);

endinterface

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      stages <= '1;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with mid-bit sampling
// and a single-entry valid/ready holding register for the received byte.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic             i_RX_Serial,
  uart_rx_stream_if.master rx_stream,
  output logic             o_RX_Active,
  output logic             o_RX_Frame_Err,
  output logic             o_RX_Parity_Err,
  output logic             o_RX_Overrun
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state, state_next;
  logic [CNT_W-1:0]          clk_cnt, clk_cnt_next;
  logic [2:0]                bit_idx, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic                      rx_line;
  logic                      stop_done;
  logic                      parity_hit;
  logic                      commit_pending;
`ifdef UART_RX_PARITY_EN
  logic                      parity_bad, parity_bad_next;
`endif

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .async_in(i_RX_Serial),
    .sync_out(rx_line)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_idx   <= bit_idx_next;
      shift_reg <= shift_next;
    end
  end

  // The START wait is half a bit, so every later sample lands mid-bit.
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt + 1'b1;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    stop_done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_next = parity_bad;
`endif
    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
        parity_bad_next = 1'b0;
`endif
        if (!rx_line) state_next = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_next = '0;
          state_next   = rx_line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next        = '0;
          shift_next[bit_idx] = rx_line;
          if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next    = '0;
          parity_bad_next = (rx_line != (^shift_reg));
          state_next      = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_next = '0;
          stop_done    = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        clk_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      parity_bad      <= 1'b0;
      o_RX_Parity_Err <= 1'b0;
    end else begin
      parity_bad      <= parity_bad_next;
      o_RX_Parity_Err <= parity_hit;
    end
  end

  assign parity_hit = stop_done && parity_bad;
`else
  assign parity_hit      = 1'b0;
  assign o_RX_Parity_Err = 1'b0;
`endif

  // A completed byte waits one cycle in shift_reg, then either fills the holding register or is dropped.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_stream.o_RX_Byte        <= '0;
      rx_stream.o_RX_Byte_tvalid <= 1'b0;
      o_RX_Frame_Err             <= 1'b0;
      o_RX_Overrun               <= 1'b0;
      commit_pending             <= 1'b0;
    end else begin
      o_RX_Frame_Err <= stop_done && !rx_line;
      commit_pending <= stop_done && rx_line && !parity_hit;
      o_RX_Overrun   <= 1'b0;
      if (commit_pending) begin
        if (!rx_stream.o_RX_Byte_tvalid || rx_stream.i_RX_Byte_tready) begin
          rx_stream.o_RX_Byte        <= shift_reg;
          rx_stream.o_RX_Byte_tvalid <= 1'b1;
        end else begin
          o_RX_Overrun <= 1'b1;
        end
      end else if (rx_stream.o_RX_Byte_tvalid && rx_stream.i_RX_Byte_tready) begin
        rx_stream.o_RX_Byte_tvalid <= 1'b0;
      end
    end
  end

  assign o_RX_Active = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at 16 clocks per bit; covers UART_RX_PARITY_EN builds too.
module tb_uart_rx_stream;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LATENCY       = 171;
  localparam int PARITY_ERRORS = 1;
`else
  localparam int LATENCY       = 155;
  localparam int PARITY_ERRORS = 0;
`endif

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic rx_serial = 1'b1;
  logic active, frame_err, parity_err, overrun;

  int check_count = 0;
  int error_count = 0;
  int frame_cnt   = 0;
  int parity_cnt  = 0;
  int overrun_cnt = 0;
  int accept_cnt  = 0;
  logic [7:0] last_byte = 8'h00;

  int         latency;
  int         active_gaps;
  logic [7:0] byte_at_valid;
  logic       wait_expired;
`ifdef UART_RX_PARITY_EN
  logic       flip_parity = 1'b0;
`endif

  uart_rx_stream_if rx_if ();

  uart_rx_stream #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_RX_Serial    (rx_serial),
    .rx_stream      (rx_if.master),
    .o_RX_Active    (active),
    .o_RX_Frame_Err (frame_err),
    .o_RX_Parity_Err(parity_err),
    .o_RX_Overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Pulses and handshakes are tallied on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err)  frame_cnt++;
      if (parity_err) parity_cnt++;
      if (overrun)    overrun_cnt++;
      if (rx_if.o_RX_Byte_tvalid && rx_if.i_RX_Byte_tready) begin
        accept_cnt++;
        last_byte = rx_if.o_RX_Byte;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic driveBit(input logic b);
    rx_serial = b;
    waitCycles(CPB);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
    driveBit((^data) ^ flip_parity);
`endif
    driveBit(stop_bit);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rx_if.i_RX_Byte_tready = 1'b1;
    waitCycles(5);
    checkOutput("reset_tvalid",     rx_if.o_RX_Byte_tvalid, 0);
    checkOutput("reset_byte",       rx_if.o_RX_Byte,        0);
    checkOutput("reset_active",     active,                 0);
    checkOutput("reset_frame_err",  frame_err,              0);
    checkOutput("reset_parity_err", parity_err,             0);
    checkOutput("reset_overrun",    overrun,                0);
    rst_n = 1'b1;
    waitCycles(5);

    $display("[TB] frame 0xA5 with latency measurement");
    latency       = 0;
    active_gaps   = 0;
    byte_at_valid = 8'h00;
    fork
      applyStimulus(8'hA5, 1'b1);
      begin
        @(posedge clk);
        for (int c = 1; c <= 400; c++) begin
          @(posedge clk);
          #1;
          if (rx_if.o_RX_Byte_tvalid) begin
            latency       = c;
            byte_at_valid = rx_if.o_RX_Byte;
            break;
          end
          if (c >= 2 && c <= LATENCY - 2 && !active) active_gaps++;
        end
      end
    join
    waitCycles(2);
    checkOutput("a5_latency",      latency,                LATENCY);
    checkOutput("a5_byte",         byte_at_valid,          8'hA5);
    checkOutput("a5_active_gaps",  active_gaps,            0);
    checkOutput("a5_accepted",     accept_cnt,             1);
    checkOutput("a5_tvalid_clear", rx_if.o_RX_Byte_tvalid, 0);
    checkOutput("a5_errors",       frame_cnt + parity_cnt + overrun_cnt, 0);

    $display("[TB] start-bit glitch then 0x3C");
    rx_serial = 1'b0;
    waitCycles(3);
    rx_serial = 1'b1;
    waitCycles(40);
    checkOutput("glitch_active",   active,     0);
    checkOutput("glitch_accepts",  accept_cnt, 1);
    checkOutput("glitch_errors",   frame_cnt + parity_cnt + overrun_cnt, 0);
    applyStimulus(8'h3C, 1'b1);
    waitCycles(5);
    checkOutput("3c_accepted",     accept_cnt, 2);
    checkOutput("3c_byte",         last_byte,  8'h3C);

    $display("[TB] 0x55 with low stop bit");
    applyStimulus(8'h55, 1'b0);
    rx_serial = 1'b1;
    waitCycles(40);
    checkOutput("frame_err_pulses", frame_cnt,              1);
    checkOutput("frame_err_tvalid", rx_if.o_RX_Byte_tvalid, 0);
    checkOutput("frame_err_accept", accept_cnt,             2);

    $display("[TB] overrun with consumer stalled");
    rx_if.i_RX_Byte_tready = 1'b0;
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    waitCycles(5);
    checkOutput("overrun_tvalid", rx_if.o_RX_Byte_tvalid, 1);
    checkOutput("overrun_byte",   rx_if.o_RX_Byte,        8'h11);
    checkOutput("overrun_pulses", overrun_cnt,            1);
    rx_if.i_RX_Byte_tready = 1'b1;
    waitCycles(1);
    rx_if.i_RX_Byte_tready = 1'b0;
    checkOutput("overrun_drain_tvalid", rx_if.o_RX_Byte_tvalid, 0);
    checkOutput("overrun_drain_accept", accept_cnt,             3);
    checkOutput("overrun_drain_byte",   last_byte,              8'h11);

    $display("[TB] tready raised in the commit cycle");
    applyStimulus(8'h11, 1'b1);
    wait_expired = 1'b1;
    fork
      applyStimulus(8'h22, 1'b1);
      begin
        for (int c = 0; c < 100; c++) begin
          @(posedge clk);
          #1;
          if (active) break;
        end
        for (int c = 0; c < 400; c++) begin
          @(posedge clk);
          #1;
          if (!active) begin
            wait_expired = 1'b0;
            break;
          end
        end
        rx_if.i_RX_Byte_tready = 1'b1;
        waitCycles(1);
        rx_if.i_RX_Byte_tready = 1'b0;
      end
    join
    checkOutput("commit_wait_expired", wait_expired,           0);
    checkOutput("commit_tvalid",       rx_if.o_RX_Byte_tvalid, 1);
    checkOutput("commit_byte",         rx_if.o_RX_Byte,        8'h22);
    checkOutput("commit_overrun",      overrun_cnt,            1);
    checkOutput("commit_accepted",     accept_cnt,             4);
    checkOutput("commit_old_byte",     last_byte,              8'h11);
    rx_if.i_RX_Byte_tready = 1'b1;
    waitCycles(2);
    checkOutput("commit_drain_accept", accept_cnt,             5);
    checkOutput("commit_drain_byte",   last_byte,              8'h22);
    checkOutput("commit_drain_tvalid", rx_if.o_RX_Byte_tvalid, 0);

    $display("[TB] reset in the middle of a frame");
    fork
      applyStimulus(8'h5A, 1'b1);
      begin
        waitCycles(60);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_active",  active,                 0);
        checkOutput("midreset_tvalid",  rx_if.o_RX_Byte_tvalid, 0);
        checkOutput("midreset_byte",    rx_if.o_RX_Byte,        0);
        checkOutput("midreset_frame",   frame_err,              0);
        checkOutput("midreset_overrun", overrun,                0);
      end
    join
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(200);
    checkOutput("postreset_accept", accept_cnt,             5);
    checkOutput("postreset_tvalid", rx_if.o_RX_Byte_tvalid, 0);
    checkOutput("postreset_active", active,                 0);

`ifdef UART_RX_PARITY_EN
    $display("[TB] 0x07 with wrong parity bit");
    flip_parity = 1'b1;
    applyStimulus(8'h07, 1'b1);
    flip_parity = 1'b0;
    waitCycles(10);
    checkOutput("parity_frame",  frame_cnt,              1);
    checkOutput("parity_accept", accept_cnt,             5);
    checkOutput("parity_tvalid", rx_if.o_RX_Byte_tvalid, 0);
`endif
    checkOutput("parity_pulses", parity_cnt, PARITY_ERRORS);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
UART receiver, the receive-side counterpart to the team's uart_tx serialiser. Synchronises the asynchronous serial line and detects start bits with mid-bit sampling, then deserialises 8N1 frames LSB-first. Received bytes are presented through a single-entry valid/ready holding register, so downstream logic (command parser, loopback to uart_tx) can stall for a byte time without losing data.

Parameters:
CLKS_PER_BIT, 104, clock cycles per bit (12 MHz / 115200); must be >= 8
SYNC_STAGES, 2, flip-flops in the i_RX_Serial synchroniser; must be >= 2

Ports:
i_Clock  in  1  system clock, all logic on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_RX_Serial  in  1  asynchronous serial line, idle high
o_RX_Byte  out  8  received byte, valid while o_RX_Byte_tvalid=1
o_RX_Byte_tvalid  out  1  holding register full
i_RX_Byte_tready  in  1  consumer accepts byte when tvalid&&tready
o_RX_Active  out  1  high from start-bit detect until stop-bit sample
o_RX_Frame_Err  out  1  one-cycle pulse, stop bit sampled low
o_RX_Parity_Err  out  1  one-cycle pulse, parity mismatch (tied 0 without macro)
o_RX_Overrun  out  1  one-cycle pulse, completed byte dropped because holding register was full

Behaviour:
- Reset: synchroniser flops reset to 1; FSM=IDLE; bit counter, clock counter, o_RX_Byte=0; all outputs 0. Reset mid-frame aborts the frame with no outputs.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: synchronised line low -> START, clock counter cleared, o_RX_Active=1.
- START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. Low -> DATA. High -> glitch, return to IDLE with no error pulse.
- DATA: wait CLKS_PER_BIT cycles per bit and sample at each interval end. Shift into bit index 0..7 (LSB first). After bit 7 -> PARITY or STOP.
- STOP: wait CLKS_PER_BIT, sample, then -> IDLE and o_RX_Active=0.
  - Sample high and no parity error: commit the byte.
  - Sample low: pulse o_RX_Frame_Err and discard the byte.
- Return to IDLE occurs at mid-stop-bit. A start edge arriving half a bit later is detected, so back-to-back frames are supported.
- Commit, cycle after stop sample:
  - Register empty, or tvalid&&tready this cycle: load o_RX_Byte and set tvalid=1.
  - Otherwise: pulse o_RX_Overrun and drop the new byte. The old byte and tvalid are unchanged.
- tvalid clears on the cycle after tvalid&&tready, unless a commit occurs in the same cycle. o_RX_Byte is stable while tvalid=1.
- Latency, pin falling edge to tvalid rising: SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (+CLKS_PER_BIT with parity).
- Counters: clock counter width $clog2(CLKS_PER_BIT); bit index 3 bits; no wrap beyond 7.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. PARITY state samples one extra bit after bit 7. Expected bit = XOR of the 8 data bits (even parity). On mismatch, pulse o_RX_Parity_Err in the stop-sample cycle and discard the byte. If the stop bit is also low, both error pulses fire.
- Undefined: 8N1; PARITY state absent; o_RX_Parity_Err constant 0.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - UART_DATA_BITS=8
  - default CLKS_PER_BIT constant, shared with uart_tx
- Sub-module uart_rx_sync: SYNC_STAGES-deep reset-to-1 synchroniser. The single-bit CDC lives there for lint/CDC waivers.

Test Plan:
All scenarios use CLKS_PER_BIT=16, SYNC_STAGES=2, tready=1 unless stated.
- Send 0xA5 as 8N1 -> o_RX_Byte=0xA5 and tvalid rises 155 cycles after the start edge; o_RX_Active high throughout; no error pulses.
- 3-cycle low glitch on idle line -> FSM returns to IDLE; no tvalid or error pulse; a following 0x3C is received correctly.
- Send 0x55 with stop bit driven low -> one o_RX_Frame_Err pulse; tvalid stays 0.
- tready=0; send 0x11 then 0x22 back-to-back -> tvalid=1 with 0x11; one o_RX_Overrun pulse at the second commit; byte stays 0x11. Raise tready -> accepted; tvalid falls.
- Assert tready exactly in the commit cycle of the second byte -> 0x11 consumed, 0x22 loaded, tvalid remains 1, no overrun.
- Assert i_Rst_n=0 mid-DATA of a frame -> all outputs 0 immediately; after release, idle line yields no byte; with UART_RX_PARITY_EN, 0x07 sent with odd parity bit -> o_RX_Parity_Err pulse and no tvalid.
